// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose:
//   Sequences PC redirects for the pipelined datapath. Branch (EX), jump-register
//   (EX) and jump (ID) requests are arbitrated br > jr > j. With fetch ready
//   (ihit=1) the winner goes to the PC in the same cycle. With fetch stalled it
//   is captured in a pending register and applied on the first ihit cycle; a
//   strictly higher-priority request arriving meanwhile replaces it. After every
//   applied redirect, the next SQUASH_SLOTS fetch slots are flagged wrong-path.
//   A committed halt freezes the PC until reset.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit                 instruction fetch complete this cycle
//   halt                 halt instruction committed
//   br_req/br_imm        taken branch and its offset
//   jr_req/jr_addr       jump-register and its target
//   j_req/j_imm          jump and its target field
//   pc_Branch/pc_Jump/pc_JR, pc_imm/pc_jimm/pc_jraddr, pc_ihit  PC controls
//   squash               current fetch slot is wrong-path
//   busy                 a redirect is pending
//   halted               halt latched
//   redirect_cnt         redirects applied (saturating)
//   stall_cnt            cycles spent pending (saturating)
//
// Configuration:
//   PC_REDIRECT_STATS_EN  when defined, redirect_cnt/stall_cnt are live
//                         counters; otherwise both read 16'h0000 and no counter
//                         flops are built.
// ----------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter int SQUASH_SLOTS = 1,
  parameter int IMM_W        = 16,
  parameter int ADDR_W       = 26,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              halt,
  input  logic              br_req,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic              jr_req,
  input  logic [WORD_W-1:0] jr_addr,
  input  logic              j_req,
  input  logic [ADDR_W-1:0] j_imm,
  output logic              pc_Branch,
  output logic              pc_Jump,
  output logic              pc_JR,
  output logic [IMM_W-1:0]  pc_imm,
  output logic [ADDR_W-1:0] pc_jimm,
  output logic [WORD_W-1:0] pc_jraddr,
  output logic              pc_ihit,
  output logic              squash,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       redirect_cnt,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Redirect kinds are encoded so that a larger value means higher priority;
  // "no redirect" is the smallest, which lets one magnitude compare serve both
  // the IDLE capture and the PEND overwrite decision.
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_J    = 2'd1;
  localparam logic [1:0] K_JR   = 2'd2;
  localparam logic [1:0] K_BR   = 2'd3;

  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_SLOTS);

  state_t              state_r, state_nxt_s;
  logic [1:0]          pend_kind_r;
  logic [IMM_W-1:0]    pend_imm_r;
  logic [ADDR_W-1:0]   pend_jimm_r;
  logic [WORD_W-1:0]   pend_jraddr_r;
  logic [1:0]          squash_cnt_r;

  logic [1:0]          req_kind_s;
  logic                take_req_s;
  logic [1:0]          sel_kind_s;
  logic [IMM_W-1:0]    sel_imm_s;
  logic [ADDR_W-1:0]   sel_jimm_s;
  logic [WORD_W-1:0]   sel_jraddr_s;
  logic [1:0]          drv_kind_s;
  logic                apply_s;

  // Fixed-priority arbitration of the incoming requests.
  always_comb begin
    req_kind_s = K_NONE;
    if (br_req) begin
      req_kind_s = K_BR;
    end else if (jr_req) begin
      req_kind_s = K_JR;
    end else if (j_req) begin
      req_kind_s = K_J;
    end else begin
      req_kind_s = K_NONE;
    end
  end

  // Candidate redirect: the new request wins only if strictly higher priority
  // than whatever is pending (pending kind is K_NONE outside PEND).
  always_comb begin
    take_req_s   = (req_kind_s > pend_kind_r);
    sel_kind_s   = pend_kind_r;
    sel_imm_s    = pend_imm_r;
    sel_jimm_s   = pend_jimm_r;
    sel_jraddr_s = pend_jraddr_r;
    if (take_req_s) begin
      sel_kind_s   = req_kind_s;
      sel_imm_s    = br_imm;
      sel_jimm_s   = j_imm;
      sel_jraddr_s = jr_addr;
    end else begin
      sel_kind_s   = pend_kind_r;
      sel_imm_s    = pend_imm_r;
      sel_jimm_s   = pend_jimm_r;
      sel_jraddr_s = pend_jraddr_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; halt overrides everything and is sticky.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
        end else if ((req_kind_s != K_NONE) && !ihit) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
        end else if (ihit) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: which redirect kind the PC sees and whether the PC advances.
  // In IDLE only an ihit cycle forwards a request; in PEND the pending (or
  // overwriting) redirect is shown every cycle so the PC has it on ihit.
  always_comb begin
    drv_kind_s = K_NONE;
    pc_ihit    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_ihit = ihit;
        if (!halt && ihit) begin
          drv_kind_s = req_kind_s;
        end else begin
          drv_kind_s = K_NONE;
        end
      end
      ST_PEND: begin
        pc_ihit = ihit;
        if (!halt) begin
          drv_kind_s = sel_kind_s;
        end else begin
          drv_kind_s = K_NONE;
        end
      end
      ST_HALT: begin
        pc_ihit    = 1'b0;
        drv_kind_s = K_NONE;
      end
      default: begin
        pc_ihit    = 1'b0;
        drv_kind_s = K_NONE;
      end
    endcase
  end

  // PC control decode; payloads of unselected kinds are forced to zero.
  always_comb begin
    pc_Branch = (drv_kind_s == K_BR);
    pc_JR     = (drv_kind_s == K_JR);
    pc_Jump   = (drv_kind_s == K_J);
    pc_imm    = {IMM_W{1'b0}};
    pc_jimm   = {ADDR_W{1'b0}};
    pc_jraddr = {WORD_W{1'b0}};
    if (pc_Branch) begin
      pc_imm = sel_imm_s;
    end else begin
      pc_imm = {IMM_W{1'b0}};
    end
    if (pc_Jump) begin
      pc_jimm = sel_jimm_s;
    end else begin
      pc_jimm = {ADDR_W{1'b0}};
    end
    if (pc_JR) begin
      pc_jraddr = sel_jraddr_s;
    end else begin
      pc_jraddr = {WORD_W{1'b0}};
    end
  end

  // A redirect takes effect only when the PC actually advances.
  assign apply_s = (drv_kind_s != K_NONE) && ihit;

  // Pending redirect register: cleared on apply or halt, loaded on capture or
  // higher-priority overwrite.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_kind_r   <= K_NONE;
      pend_imm_r    <= {IMM_W{1'b0}};
      pend_jimm_r   <= {ADDR_W{1'b0}};
      pend_jraddr_r <= {WORD_W{1'b0}};
    end else if (halt || apply_s) begin
      pend_kind_r   <= K_NONE;
      pend_imm_r    <= {IMM_W{1'b0}};
      pend_jimm_r   <= {ADDR_W{1'b0}};
      pend_jraddr_r <= {WORD_W{1'b0}};
    end else if ((state_r != ST_HALT) && take_req_s) begin
      pend_kind_r   <= req_kind_s;
      pend_imm_r    <= br_imm;
      pend_jimm_r   <= j_imm;
      pend_jraddr_r <= jr_addr;
    end else begin
      pend_kind_r   <= pend_kind_r;
      pend_imm_r    <= pend_imm_r;
      pend_jimm_r   <= pend_jimm_r;
      pend_jraddr_r <= pend_jraddr_r;
    end
  end

  // Squash counter: reloaded by each redirect, counts down on plain ihit cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      squash_cnt_r <= 2'd0;
    end else if (apply_s) begin
      squash_cnt_r <= SQ_LOAD;
    end else if (ihit && (squash_cnt_r != 2'd0)) begin
      squash_cnt_r <= squash_cnt_r - 2'd1;
    end else begin
      squash_cnt_r <= squash_cnt_r;
    end
  end

  assign squash = (squash_cnt_r != 2'd0);
  assign busy   = (state_r == ST_PEND);
  assign halted = (state_r == ST_HALT);

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] redirect_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_cnt_r <= 16'h0000;
      stall_cnt_r    <= 16'h0000;
    end else begin
      if (apply_s && (redirect_cnt_r != 16'hFFFF)) begin
        redirect_cnt_r <= redirect_cnt_r + 16'h0001;
      end else begin
        redirect_cnt_r <= redirect_cnt_r;
      end
      if ((state_r == ST_PEND) && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_r;
  assign stall_cnt    = stall_cnt_r;
`else
  assign redirect_cnt = 16'h0000;
  assign stall_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam int SQ = 1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        halt = 1'b0;
  logic        br_req = 1'b0;
  logic [15:0] br_imm = 16'h0;
  logic        jr_req = 1'b0;
  logic [31:0] jr_addr = 32'h0;
  logic        j_req = 1'b0;
  logic [25:0] j_imm = 26'h0;
  logic        pc_Branch, pc_Jump, pc_JR, pc_ihit, squash, busy, halted;
  logic [15:0] pc_imm;
  logic [25:0] pc_jimm;
  logic [31:0] pc_jraddr;
  logic [15:0] redirect_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: what is waiting for the PC, whether halted, squash slots
  // remaining, and the statistics.
  bit          m_halted;
  bit          m_pv;
  int          m_pp;     // priority of pending redirect: 3 br, 2 jr, 1 j
  logic [15:0] m_imm;
  logic [25:0] m_jimm;
  logic [31:0] m_jra;
  int          m_sq;
  int          m_rcnt;
  int          m_scnt;

  pc_redirect_ctrl #(.SQUASH_SLOTS(SQ)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .halt(halt),
    .br_req(br_req), .br_imm(br_imm), .jr_req(jr_req), .jr_addr(jr_addr),
    .j_req(j_req), .j_imm(j_imm),
    .pc_Branch(pc_Branch), .pc_Jump(pc_Jump), .pc_JR(pc_JR),
    .pc_imm(pc_imm), .pc_jimm(pc_jimm), .pc_jraddr(pc_jraddr),
    .pc_ihit(pc_ihit), .squash(squash), .busy(busy), .halted(halted),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
`ifdef PC_REDIRECT_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    m_halted = 0; m_pv = 0; m_pp = 0;
    m_imm = 16'h0; m_jimm = 26'h0; m_jra = 32'h0;
    m_sq = 0; m_rcnt = 0; m_scnt = 0;
  endtask

  // One clock cycle: drive inputs, predict, check mid-cycle, advance model.
  // Called at posedge+1.
  task automatic cyc(input bit b, input logic [15:0] bi, input bit r, input logic [31:0] ra,
                     input bit j, input logic [25:0] ji, input bit ih, input bit hl);
    int          rq_p, dp;
    bit          dv, applied;
    logic [15:0] d_imm;
    logic [25:0] d_jimm;
    logic [31:0] d_jra;
    br_req = b; br_imm = bi; jr_req = r; jr_addr = ra; j_req = j; j_imm = ji;
    ihit = ih; halt = hl;
    rq_p = b ? 3 : (r ? 2 : (j ? 1 : 0));
    dv = 0; dp = 0; d_imm = 16'h0; d_jimm = 26'h0; d_jra = 32'h0;
    if (!m_halted && !hl) begin
      if (m_pv) begin
        dv = 1;
        if (rq_p > m_pp) begin
          dp = rq_p; d_imm = bi; d_jimm = ji; d_jra = ra;
        end else begin
          dp = m_pp; d_imm = m_imm; d_jimm = m_jimm; d_jra = m_jra;
        end
      end else if (ih && rq_p != 0) begin
        dv = 1; dp = rq_p; d_imm = bi; d_jimm = ji; d_jra = ra;
      end
    end
    @(negedge CLK);
    chk("pc_Branch", {31'h0, pc_Branch}, {31'h0, (dv && dp == 3)});
    chk("pc_JR", {31'h0, pc_JR}, {31'h0, (dv && dp == 2)});
    chk("pc_Jump", {31'h0, pc_Jump}, {31'h0, (dv && dp == 1)});
    chk("pc_imm", {16'h0, pc_imm}, {16'h0, ((dv && dp == 3) ? d_imm : 16'h0)});
    chk("pc_jraddr", pc_jraddr, (dv && dp == 2) ? d_jra : 32'h0);
    chk("pc_jimm", {6'h0, pc_jimm}, {6'h0, ((dv && dp == 1) ? d_jimm : 26'h0)});
    chk("pc_ihit", {31'h0, pc_ihit}, {31'h0, (!m_halted && ih)});
    chk("squash", {31'h0, squash}, {31'h0, (m_sq != 0)});
    chk("busy", {31'h0, busy}, {31'h0, m_pv});
    chk("halted", {31'h0, halted}, {31'h0, m_halted});
    chk("redirect_cnt", {16'h0, redirect_cnt}, 32'(stat_exp(m_rcnt)));
    chk("stall_cnt", {16'h0, stall_cnt}, 32'(stat_exp(m_scnt)));
    @(posedge CLK);
    applied = dv && ih;
    if (m_pv && m_scnt < 65535) m_scnt++;
    if (applied && m_rcnt < 65535) m_rcnt++;
    if (applied) m_sq = SQ;
    else if (ih && m_sq > 0) m_sq--;
    if (hl) begin
      m_halted = 1; m_pv = 0;
    end else if (!m_halted) begin
      if (m_pv) begin
        if (ih) m_pv = 0;
        else begin
          m_pp = dp; m_imm = d_imm; m_jimm = d_jimm; m_jra = d_jra;
        end
      end else if (rq_p != 0 && !ih) begin
        m_pv = 1; m_pp = rq_p; m_imm = bi; m_jimm = ji; m_jra = ra;
      end
    end
    #1;
  endtask

  task automatic idle_cyc(input bit ih);
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 26'h0, ih, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 0;
    br_req = 0; jr_req = 0; j_req = 0; ihit = 0; halt = 0;
    br_imm = 16'h0; jr_addr = 32'h0; j_imm = 26'h0;
    model_reset();
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_squash", {31'h0, squash}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_ctrl", {29'h0, pc_Branch, pc_JR, pc_Jump}, 32'h0);
    chk("rst_rcnt", {16'h0, redirect_cnt}, 32'h0);
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Immediate branch, then squash window.
    cyc(1'b1, 16'h0004, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b0);
    chk("t1_squash_set", {31'h0, squash}, 32'h1);
    idle_cyc(1'b1);
    chk("t1_squash_clr", {31'h0, squash}, 32'h0);
    idle_cyc(1'b1);

    // Stalled jump: capture, two stall cycles, apply on ihit.
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 26'h0000100, 1'b0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    chk("t2_busy_before_ihit", {31'h0, busy}, 32'h1);
    idle_cyc(1'b1);
    chk("t2_stall_cnt", {16'h0, stall_cnt}, 32'(stat_exp(3)));
    idle_cyc(1'b1);

    // Pending jump overwritten by branch; later jump ignored.
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 26'h0000200, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFC, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
    idle_cyc(1'b0);
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 26'h0000300, 1'b0, 1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // Same-cycle request with ihit inside PEND: overwrite then apply.
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 26'h0000400, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 32'h0000_0080, 1'b0, 26'h0, 1'b1, 1'b0);
    idle_cyc(1'b1);

    // All three requests at once.
    cyc(1'b1, 16'h0010, 1'b1, 32'h0000_0040, 1'b1, 26'h0000100, 1'b1, 1'b0);
    idle_cyc(1'b1);

    // Halt during PEND, then requests are ignored.
    cyc(1'b0, 16'h0, 1'b1, 32'h0000_0040, 1'b0, 26'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b1);
    idle_cyc(1'b1);
    chk("t5_halted", {31'h0, halted}, 32'h1);
    cyc(1'b0, 16'h0, 1'b1, 32'h0000_0044, 1'b0, 26'h0, 1'b1, 1'b0);
    do_reset();

    // Asynchronous reset mid-PEND with squash active.
    cyc(1'b1, 16'h0008, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 26'h0000010, 1'b0, 1'b0);
    chk("t6_busy_pre", {31'h0, busy}, 32'h1);
    chk("t6_squash_pre", {31'h0, squash}, 32'h1);
    j_req = 0; ihit = 0;
    #2;
    nRST = 0;
    #1;
    chk("t6_busy_async", {31'h0, busy}, 32'h0);
    chk("t6_squash_async", {31'h0, squash}, 32'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
    idle_cyc(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 5) == 0), 16'($urandom),
            ($urandom_range(0, 5) == 0), $urandom,
            ($urandom_range(0, 4) == 0), 26'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequences PC redirects for the pipelined datapath. Collects branch, jump and jump-register requests from the pipeline and arbitrates them by priority. Holds a redirect that arrives while instruction fetch is stalled (`ihit` low) until the fetch completes. Drives the program counter's `Branch`/`Jump`/`JR`/`imm`/`jimm`/`jraddr`/`ihit` inputs, and flags the wrong-path fetch slots that follow each redirect for squashing.

## Interface
- `SQUASH_SLOTS`, default 1: number of fetch slots after an applied redirect that are marked invalid (range 0–3).
- `CLK` in 1: system clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch complete this cycle.
- `halt` in 1: halt instruction committed.
- `br_req` in 1: taken branch resolved (EX stage).
- `br_imm` in IMM_W: branch offset.
- `jr_req` in 1: jump-register (EX stage).
- `jr_addr` in word_t: JR target.
- `j_req` in 1: jump (ID stage).
- `j_imm` in ADDR_W: jump target field.
- `pc_Branch` out 1: PC control.
- `pc_Jump` out 1: PC control.
- `pc_JR` out 1: PC control.
- `pc_imm` out IMM_W: PC branch offset.
- `pc_jimm` out ADDR_W: PC jump target field.
- `pc_jraddr` out word_t: PC JR target.
- `pc_ihit` out 1: PC advance enable.
- `squash` out 1: current fetch slot is wrong-path.
- `busy` out 1: a redirect is pending.
- `halted` out 1: halt latched.
- `redirect_cnt` out 16: redirects applied (stats).
- `stall_cnt` out 16: cycles spent in PEND (stats).

## Operation
- States:
  - IDLE: no pending redirect.
  - PEND: redirect captured, waiting for `ihit`.
  - HALT: PC frozen.
- Priority among simultaneous requests: br > jr > j. Branch and JR come from an older instruction than a jump.
- IDLE with a winning request and `ihit`=1:
  - Drive that request to the PC combinationally: exactly one of `pc_Branch`/`pc_JR`/`pc_Jump` is high, with its payload.
  - Load the squash counter with `SQUASH_SLOTS`.
  - Increment `redirect_cnt`. Stay in IDLE.
- IDLE with a winning request and `ihit`=0:
  - Latch kind and payload into the pending register. Go to PEND.
  - PC controls stay low this cycle.
- PEND:
  - Drive the PC controls from the pending register.
  - A new request of strictly higher priority than the pending kind overwrites the register. Equal or lower priority is ignored.
  - On `ihit`=1: apply the (possibly overwritten) redirect, load the squash counter, increment `redirect_cnt`, go to IDLE.
- Payload fields not selected are driven 0.
- Squash counter (2 bit):
  - `squash` = (counter != 0).
  - Decrements on each `ihit` cycle in which no redirect is applied.
  - A new redirect reloads it.
- `halt`=1 from any state → HALT.
  - `halt` takes precedence over any same-cycle request; a pending redirect is discarded.
  - In HALT: `pc_ihit`=0, all PC controls 0, `halted`=1. HALT is left only by reset.
- Outside HALT: `pc_ihit` = `ihit`.
- `busy` = (state == PEND).
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - state IDLE, pending register 0, squash counter 0, stats counters 0.
  - `squash`, `busy`, `halted` = 0.
  - PC controls 0 while no request is present.
- Assertion of `nRST` mid-PEND discards the pending redirect immediately, without waiting for a clock edge.
- Latency, immediate redirect: 0 cycles (request to PC controls combinational in IDLE).
- Latency, stalled redirect: applied in the first cycle with `ihit`=1. PC controls are visible from the cycle after capture onward.
- `squash` is asserted from the cycle after the redirect is applied, for `SQUASH_SLOTS` `ihit` cycles.
- `SQUASH_SLOTS`=0: `squash` never asserts (delay-slot mode).
- Request pulse and `ihit` rising in the same cycle while in PEND: overwrite rule first, then apply in that cycle.

## Configuration
- `PC_REDIRECT_STATS_EN` defined: `redirect_cnt` and `stall_cnt` are live saturating counters.
  - `stall_cnt` increments every cycle the block is in PEND.
- Not defined: both ports are tied to 16'h0000 and no counter flops are built.

## Test plan
- Reset, then `br_req`=1, `br_imm`=16'h0004, `ihit`=1 → same cycle `pc_Branch`=1, `pc_imm`=16'h0004. Next cycle `squash`=1; with `SQUASH_SLOTS`=1, `squash`=0 after one further `ihit`.
- `j_req`=1, `j_imm`=26'h0000100, `ihit`=0 for 3 cycles then 1 → `busy`=1 for 3 cycles, `pc_Jump`=1 with `pc_jimm`=26'h0000100 held, redirect applied on the `ihit` cycle, `stall_cnt`=3.
- While PEND holds a jump, pulse `br_req` (`br_imm`=16'hFFFC) → pending overwritten, `pc_Branch`=1. Pulsing `j_req` instead → ignored.
- Same cycle `br_req`, `jr_req` (`jr_addr`=32'h0000_0040) and `j_req` with `ihit`=1 → only `pc_Branch`=1, `redirect_cnt` +1.
- `halt`=1 during PEND → pending dropped, `halted`=1, `pc_ihit`=0 with `ihit`=1. A subsequent `jr_req` produces no PC control.
- `nRST` low mid-PEND → `busy`=0 and `squash`=0 asynchronously; after release, `ihit`=1 produces no redirect.
